// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared control-bundle constants for the MIPS pipeline
// Purpose: bit positions inside the 8-bit decode control bundle, ALUOp
//          encodings and the all-zero bubble bundle.
// Ports:   none (package)
package pipe_pkg;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  localparam logic [7:0] BUBBLE_CTRL = 8'h00;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - load-use hazard compare bundle
// Purpose: groups the EX-side load info and ID-side source registers fed to
//          the hazard comparator, plus the hazard result.
// Ports:   master drives the operands and reads hazard;
//          slave reads the operands and drives hazard.
interface id_ex_stage_if;

  logic       mem_read_ex;
  logic [4:0] rt_addr_ex;
  logic [4:0] rs_addr_id;
  logic [4:0] rt_addr_id;
  logic       flush;
  logic       hazard;

  modport master (
    output mem_read_ex, rt_addr_ex, rs_addr_id, rt_addr_id, flush,
    input  hazard
  );

  modport slave (
    input  mem_read_ex, rt_addr_ex, rs_addr_id, rt_addr_id, flush,
    output hazard
  );

endinterface

// File: rtl/id_ex_stage_load_use.sv
// rtl/id_ex_stage_load_use.sv - combinational load-use hazard comparator
// Purpose: flags when the load now in EX writes a register read by the
//          instruction in ID. rt is compared for every opcode (conservative).
// Ports:   hz (slave modport of id_ex_stage_if)
module load_use_detect (
  id_ex_stage_if.slave hz
);

  logic addr_match;

  // A load to $0 never produces a value worth waiting for.
  assign addr_match = (hz.rt_addr_ex != 5'd0) &&
                      ((hz.rt_addr_ex == hz.rs_addr_id) ||
                       (hz.rt_addr_ex == hz.rt_addr_id));

  // A flush squashes the ID instruction anyway, so stalling would be wasted.
  assign hz.hazard = hz.mem_read_ex && addr_match && !hz.flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall
// Purpose: latches control, data and register fields from decode; inserts a
//          one-cycle bubble on flush or load-use hazard; counts hazard bubbles.
// Ports:   clk_i, rst_i (sync, active high); ctrl_i, rs/rt_data_i, imm_i,
//          rs/rt/rd_addr_i, flush_i in; registered control/data/address outs;
//          pc_write_o, ifid_write_o, hazard_o (combinational); bubble_cnt_o.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       ctrl_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  input  logic [31:0]      imm_i,
  input  logic [4:0]       rs_addr_i,
  input  logic [4:0]       rt_addr_i,
  input  logic [4:0]       rd_addr_i,
  input  logic             flush_i,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             alu_src_o,
  output logic             reg_dst_o,
  output logic [1:0]       alu_op_o,
  output logic [31:0]      rs_data_o,
  output logic [31:0]      rt_data_o,
  output logic [31:0]      imm_o,
  output logic [4:0]       rs_addr_o,
  output logic [4:0]       rt_addr_o,
  output logic [4:0]       rd_addr_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]       ctrl_q, ctrl_d;
  logic [31:0]      rs_data_q, rt_data_q, imm_q;
  logic [4:0]       rs_addr_q, rt_addr_q, rd_addr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  id_ex_stage_if u_hz_if ();

  assign u_hz_if.mem_read_ex = ctrl_q[CTRL_MEMREAD];
  assign u_hz_if.rt_addr_ex  = rt_addr_q;
  assign u_hz_if.rs_addr_id  = rs_addr_i;
  assign u_hz_if.rt_addr_id  = rt_addr_i;
  assign u_hz_if.flush       = flush_i;
  assign hazard              = u_hz_if.hazard;

  load_use_detect u_load_use (
    .hz (u_hz_if.slave)
  );

  always_comb begin
    // Forcing a constant keeps any don't-care decode bits out of the bubble.
    ctrl_d = (flush_i || hazard) ? BUBBLE_CTRL : ctrl_i;
    cnt_d  = cnt_q;
    if (hazard && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q    <= BUBBLE_CTRL;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_i;
      rt_data_q <= rt_data_i;
      imm_q     <= imm_i;
      rs_addr_q <= rs_addr_i;
      rt_addr_q <= rt_addr_i;
      rd_addr_q <= rd_addr_i;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_write_o  = ctrl_q[CTRL_REGWRITE];
  assign mem_to_reg_o = ctrl_q[CTRL_MEMTOREG];
  assign mem_read_o   = ctrl_q[CTRL_MEMREAD];
  assign mem_write_o  = ctrl_q[CTRL_MEMWRITE];
  assign alu_src_o    = ctrl_q[CTRL_ALUSRC];
  assign alu_op_o     = ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
  assign reg_dst_o    = ctrl_q[CTRL_REGDST];
  assign rs_data_o    = rs_data_q;
  assign rt_data_o    = rt_data_q;
  assign imm_o        = imm_q;
  assign rs_addr_o    = rs_addr_q;
  assign rt_addr_o    = rt_addr_q;
  assign rd_addr_o    = rd_addr_q;
  assign hazard_o     = hazard;
  assign pc_write_o   = !hazard;
  assign ifid_write_o = !hazard;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage MIPS core, with integrated load-use hazard detection. It sits directly downstream of the decode-stage control unit. It latches the 8-bit control bundle, register-file read data, sign-extended immediate and register addresses each cycle, and presents them to EX. When a load in EX feeds the instruction in ID, it inserts a one-cycle bubble and holds PC and IF/ID; it also counts inserted bubbles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of saturating bubble counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- ctrl_i  in  8  decode control bundle {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}, bit 7 = RegWrite
- rs_data_i, rt_data_i  in  32  register-file read data
- imm_i  in  32  sign-extended immediate
- rs_addr_i, rt_addr_i, rd_addr_i  in  5  instruction register fields
- flush_i  in  1  squash the instruction entering ID/EX
- reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o, reg_dst_o  out  1 each  registered control fields
- alu_op_o  out  2  registered ALUOp
- rs_data_o, rt_data_o, imm_o  out  32  registered data
- rs_addr_o, rt_addr_o, rd_addr_o  out  5  registered addresses
- pc_write_o  out  1  0 = hold PC this cycle
- ifid_write_o  out  1  0 = hold IF/ID this cycle
- hazard_o  out  1  load-use hazard detected this cycle
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard detection:
  - hazard_o = mem_read_o && (rt_addr_o != 0) && (rt_addr_o == rs_addr_i || rt_addr_o == rt_addr_i) && !flush_i.
  - rt is compared for every opcode. This is conservative and intended.
- pc_write_o = ifid_write_o = !hazard_o.
- Each rising edge, in priority order:
  - rst_i: all registered outputs and the counter go to 0.
  - flush_i or hazard_o: insert a bubble.
    - All eight control bits are forced to 0.
    - Data and address registers load normally; their value is don't-care because the control bits are 0.
  - otherwise: every field loads from its input.
- Any X or don't-care bit in ctrl_i (e.g. sw/beq RegDst, MemtoReg) must never propagate into a bubble.
- On a normal load, ctrl_i is captured bitwise as given.
- bubble_cnt_o increments by 1 on every bubble caused by hazard_o only. Flush bubbles are not counted. The counter saturates at all-ones.
- Stall self-release: the bubble clears mem_read_o, so hazard_o drops the next cycle. Every load-use stall lasts exactly 1 cycle.

## Timing
- Latency: input to output is 1 cycle, for all registered fields.
- hazard_o, pc_write_o and ifid_write_o are combinational from the registered outputs and same-cycle inputs, with no register stage.
- Reset values:
  - all control, data and address outputs: 0
  - bubble_cnt_o: 0
  - hazard_o: 0
  - pc_write_o and ifid_write_o: 1, since mem_read_o = 0
- Reset asserted mid-stall: the next edge clears mem_read_o, and the stall ends.
- flush_i together with a hazard condition: flush wins. hazard_o = 0, pc_write_o = 1, the bubble is inserted, and the counter does not increment.
- Back-to-back loads with a dependency: each dependent pair costs exactly 1 bubble.
- Load to $0: never stalls.

## Structure
- Shared package `pipe_pkg`:
  - control-bundle bit-index constants (CTRL_REGWRITE=7 … CTRL_REGDST=0)
  - ALUOp encodings: 00 add, 01 sub, 10 R-type
  - BUBBLE_CTRL = 8'h00
- One sub-module, `load_use_detect`: the purely combinational hazard compare. The main module holds the register and the counter.

## Test plan
- Reset: hold rst_i 2 cycles. All outputs 0, pc_write_o = 1, bubble_cnt_o = 0.
- Normal pass-through:
  - Stimulus: ctrl_i = 8'b10000101, rs_data_i = 32'h1234, rd_addr_i = 5.
  - Response: the same values appear one cycle later, hazard_o = 0.
- Load-use:
  - Stimulus: lw ctrl 8'b11101000 with rt = 8, then next cycle rs_addr_i = 8.
  - Response: hazard_o = 1 and pc_write_o = ifid_write_o = 0 for exactly 1 cycle. The next cycle's control outputs are 0, and bubble_cnt_o = 1.
- Load to $0: lw with rt = 0, followed by rs_addr_i = 0. Response: no stall, counter unchanged.
- Flush with hazard:
  - Stimulus: the load-use condition with flush_i = 1.
  - Response: hazard_o = 0, pc_write_o = 1, control outputs 0 next cycle, counter unchanged.
- Saturation, with CNT_W = 2:
  - Stimulus: 5 load-use stalls.
  - Response: bubble_cnt_o reads 1, 2, 3, 3, 3.
